// File: rtl/if_id_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buf
// Description : DEPTH-entry fetch-to-decode instruction queue with
//               valid/ready handshake, redirect flush and NOP when empty.
//               Optional macro IF_ID_BUF_BYPASS_EN adds a 0-cycle path from
//               fetch to decode while the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buf #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RST_PC   = '0,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         hold_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [ADDR_W-1:0]            pc_i,
    input  logic [INST_W-1:0]            inst_i,
    output logic                         out_valid_o,
    output logic [ADDR_W-1:0]            pc_o,
    output logic [INST_W-1:0]            inst_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0]  C_PTR_LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];

    logic w_empty, w_full, w_bypass, w_consume, w_push, w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualifiers and decode-side outputs
    always_comb begin
        w_empty = (count_q == '0);
        w_full  = (count_q == C_DEPTH);
`ifdef IF_ID_BUF_BYPASS_EN
        // Empty queue: hand the fetched instruction straight to decode
        w_bypass = w_empty & in_valid_i & ~flush_i;
`else
        w_bypass = 1'b0;
`endif
        // A bypassed instruction decode accepts now never enters the queue
        w_consume   = w_bypass & ~hold_i;
        // Ready looks only at occupancy, so a full queue refuses even when popping
        in_ready_o  = ~w_full;
        w_push      = in_valid_i & ~w_full & ~flush_i & ~w_consume;
        w_pop       = ~w_empty & ~hold_i & ~flush_i;
        out_valid_o = ~w_empty | w_bypass;
        count_o     = count_q;
        if (!w_empty) begin
            pc_o   = pc_mem_q[rd_ptr_q];
            inst_o = inst_mem_q[rd_ptr_q];
        end else if (w_bypass) begin
            pc_o   = pc_i;
            inst_o = inst_i;
        end else begin
            pc_o   = last_pc_q;
            inst_o = NOP_INST;
        end
    end

    // Next-state for pointers, occupancy, last-issued PC and storage
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_pc_d  = last_pc_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (w_push) begin
            pc_mem_d[wr_ptr_q]   = pc_i;
            inst_mem_d[wr_ptr_q] = inst_i;
        end
        if (w_pop) begin
            last_pc_d = pc_mem_q[rd_ptr_q];
        end else if (w_consume) begin
            last_pc_d = pc_i;
        end
        if (flush_i) begin
            // Redirect: drop everything; last_pc survives so decode sees a stable PC
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_pc_q <= RST_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_pc_q  <= last_pc_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buf
// Description : Self-checking bench for if_id_buf (vector table, directed
//               corner sequences, random traffic against a queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buf;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IF_ID_BUF_BYPASS_EN
    localparam bit          BYP   = 1'b1;
`else
    localparam bit          BYP   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0, hold_i = 1'b0, in_valid_i = 1'b0;
    logic        in_ready_o, out_valid_o;
    logic [31:0] pc_i = '0, inst_i = '0, pc_o, inst_o;
    logic [2:0]  count_o;

    if_id_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .hold_i(hold_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .out_valid_o(out_valid_o),
        .pc_o(pc_o), .inst_o(inst_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an ordered queue of entries plus the last issued PC
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_last = '0;

    typedef struct {
        bit          f, h, v;
        logic [31:0] pc;
        bit          ev;
        logic [31:0] epc;
        int          ecnt;
        bit          erdy;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit          byp;
        bit          ev;
        logic [31:0] epc, einst;
        byp = BYP && (mq.size() == 0) && in_valid_i && !flush_i;
        ev  = (mq.size() != 0) || byp;
        if (mq.size() != 0) begin
            epc = mq[0].pc;  einst = mq[0].inst;
        end else if (byp) begin
            epc = pc_i;      einst = inst_i;
        end else begin
            epc = m_last;    einst = NOP;
        end
        chk("model_valid", 32'(out_valid_o), 32'(ev));
        chk("model_pc",    pc_o,   epc);
        chk("model_inst",  inst_o, einst);
        chk("model_count", 32'(count_o), 32'(mq.size()));
        chk("model_ready", 32'(in_ready_o), 32'(mq.size() < DEPTH));
    endtask

    task automatic apply(input bit f, input bit h, input bit v, input logic [31:0] pc,
                         input logic [31:0] inst);
        flush_i = f; hold_i = h; in_valid_i = v; pc_i = pc; inst_i = inst;
        #1;
        model_check();
    endtask

    // Advance the model by the rules of one clock edge, then clock the DUT
    task automatic tick();
        int sz;
        bit rdy, byp, took;
        sz   = mq.size();
        rdy  = sz < DEPTH;
        byp  = BYP && (sz == 0) && in_valid_i && !flush_i;
        took = 1'b0;
        if (flush_i) begin
            mq.delete();
        end else begin
            if (sz > 0 && !hold_i) begin
                m_last = mq[0].pc;
                void'(mq.pop_front());
            end else if (byp && !hold_i) begin
                m_last = pc_i;
                took   = 1'b1;
            end
            if (in_valid_i && rdy && !took) mq.push_back({pc_i, inst_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_held(input logic [31:0] pc);
        apply(1'b0, 1'b1, 1'b1, pc, inst_of(pc));
        tick();
    endtask

    task automatic idle(input bit h);
        apply(1'b0, h, 1'b0, '0, '0);
    endtask

    initial begin
        // Fill with hold, refuse fifth input, drain in order
        tbl[0] = '{0,1,1,32'h100, BYP, BYP ? 32'h100 : 32'h0, 0, 1};
        tbl[1] = '{0,1,1,32'h104, 1, 32'h100, 1, 1};
        tbl[2] = '{0,1,1,32'h108, 1, 32'h100, 2, 1};
        tbl[3] = '{0,1,1,32'h10C, 1, 32'h100, 3, 1};
        tbl[4] = '{0,1,1,32'h110, 1, 32'h100, 4, 0};
        tbl[5] = '{0,0,1,32'h120, 1, 32'h100, 4, 0};
        tbl[6] = '{0,0,0,32'h0,   1, 32'h104, 3, 1};
        tbl[7] = '{0,0,0,32'h0,   1, 32'h108, 2, 1};
        tbl[8] = '{0,0,0,32'h0,   1, 32'h10C, 1, 1};
        tbl[9] = '{0,0,0,32'h0,   0, 32'h10C, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_check();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].f, tbl[i].h, tbl[i].v, tbl[i].pc, inst_of(tbl[i].pc));
            chk("tbl_valid", 32'(out_valid_o), 32'(tbl[i].ev));
            chk("tbl_pc",    pc_o, tbl[i].epc);
            chk("tbl_inst",  inst_o, tbl[i].ev ? inst_of(tbl[i].epc) : NOP);
            chk("tbl_count", 32'(count_o), 32'(tbl[i].ecnt));
            chk("tbl_ready", 32'(in_ready_o), 32'(tbl[i].erdy));
            tick();
        end

        // Steady push+pop at occupancy 2 across pointer wrap
        push_held(32'h500);
        push_held(32'h504);
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 1'b0, 1'b1, 32'h508 + 32'(4*k), inst_of(32'h508 + 32'(4*k)));
            chk("pp_count", 32'(count_o), 32'd2);
            chk("pp_pc", pc_o, 32'h500 + 32'(4*k));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            tick();
        end

        // Flush with a concurrent input at occupancy 3
        push_held(32'h600);
        push_held(32'h604);
        push_held(32'h608);
        apply(1'b1, 1'b0, 1'b1, 32'h200, inst_of(32'h200));
        tick();
        idle(1'b0);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        chk("flush_inst",  inst_o, NOP);
        tick();
        apply(1'b0, 1'b0, 1'b1, 32'h300, inst_of(32'h300));
        tick();
        idle(1'b0);
        chk("after_flush_pc", pc_o, 32'h300);
        tick();

        // Flush beats hold; last issued PC is retained
        push_held(32'h310);
        push_held(32'h314);
        apply(1'b1, 1'b1, 1'b0, '0, '0);
        chk("fh_count_before", 32'(count_o), 32'd2);
        tick();
        idle(1'b1);
        chk("fh_count", 32'(count_o), 32'd0);
        chk("fh_valid", 32'(out_valid_o), 32'd0);
        chk("fh_pc",    pc_o, 32'h300);
        tick();

        // Push into an empty queue with decode ready
        apply(1'b0, 1'b0, 1'b1, 32'h400, inst_of(32'h400));
        chk("byp_valid", 32'(out_valid_o), 32'(BYP));
        chk("byp_pc",    pc_o, BYP ? 32'h400 : 32'h300);
        chk("byp_count", 32'(count_o), 32'd0);
        tick();
        idle(1'b0);
        chk("byp_next_valid", 32'(out_valid_o), 32'(!BYP));
        chk("byp_next_pc",    pc_o, 32'h400);
        tick();

        // Asynchronous reset mid-run with occupancy 3
        push_held(32'h700);
        push_held(32'h704);
        push_held(32'h708);
        chk("pre_rst_count", 32'(count_o), 32'd3);
        flush_i = 1'b0; hold_i = 1'b0; in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_inst",  inst_o, NOP);
        chk("rst_pc",    pc_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        mq.delete();
        m_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply(($urandom % 16) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
                  $urandom, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_buf.md
# if_id_buf

Parametrised fetch-to-decode buffer: a DEPTH-entry instruction queue between the fetch unit and the decoder with a valid/ready handshake, replacing the single-entry fetch/decode pipeline register. It absorbs fetch bursts while decode is stalled. It discards all buffered and in-flight instructions on a control-flow redirect and presents a NOP to decode when empty.

## Interface
Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, number of queue entries; must be ≥ 2 (non-power-of-2 legal)
- RST_PC, 32'h0000_0000, reset value of pc_o
- NOP_INST, 32'h0000_0013, instruction presented when the queue is empty

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  redirect (jump/branch taken): drop all entries and this cycle's input
- hold_i  in  1  decode stall: no pop, outputs frozen
- in_valid_i  in  1  fetch presents pc_i/inst_i
- in_ready_o  out  1  buffer can accept this cycle
- pc_i  in  ADDR_W  fetched PC
- inst_i  in  INST_W  fetched instruction
- out_valid_o  out  1  pc_o/inst_o hold a real instruction
- pc_o  out  ADDR_W  PC to decode
- inst_o  out  INST_W  instruction to decode
- count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: circular array, wr_ptr/rd_ptr in 0..DEPTH-1, each wrapping DEPTH-1 → 0; count register 0..DEPTH.
- in_ready_o = (count < DEPTH); derived from registered state only, never from out-side signals.
- push = in_valid_i & in_ready_o & ~flush_i; writes {pc_i, inst_i} at wr_ptr.
- pop = out_valid_o & ~hold_i & ~flush_i; advances rd_ptr.
- count_next = count + push − pop; push and pop in the same cycle leave count unchanged.
- out_valid_o = (count != 0); inst_o = head instruction when valid, else NOP_INST.
- pc_o = head PC when valid. When empty, pc_o holds the PC of the last popped entry (register last_pc), which is RST_PC after reset.
- Flush: next cycle count=0, wr_ptr=rd_ptr=0, out_valid_o=0, inst_o=NOP_INST. last_pc keeps its value. Flush overrides hold and push.
- Hold while empty has no effect (nothing to freeze beyond NOP/last_pc).
- Full: in_ready_o=0 even if decode pops this cycle (no full-pass-through). The slot becomes available next cycle.
- Reset mid-operation: all state cleared asynchronously to the reset values below.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, pc_o=RST_PC, inst_o=NOP_INST, count_o=0, pointers 0.
- Push-to-output latency: 1 cycle (entry pushed at edge N is visible at decode after edge N).
- Pop takes effect at the clock edge; the next entry appears the same edge.
- flush_i sampled at the edge; effects are visible from the following cycle; 1-cycle bubble minimum.
- All outputs except those under the bypass option are combinational from registers only.

## Configuration
- IF_ID_BUF_BYPASS_EN defined: when count==0 and in_valid_i & ~flush_i, out_valid_o=1 and pc_o/inst_o = pc_i/inst_i combinationally (0-cycle latency). If ~hold_i, the instruction is consumed directly and not written. If hold_i, it is written as a normal push.
- Not defined: no input-to-output combinational path; latency is always 1 cycle.

## Test plan
- Reset: assert rst_n=0 mid-run with count=3 → immediately out_valid_o=0, inst_o=32'h13, pc_o=0, count_o=0, in_ready_o=1.
- Fill: hold_i=1, push PCs 0x100,0x104,0x108,0x10C → count_o=4, in_ready_o=0; a fifth valid input is not accepted; release hold → pops in order 0x100..0x10C over 4 cycles.
- Simultaneous push/pop at count=2 with hold_i=0 for 10 cycles → count_o stays 2; pointers wrap; PC order is preserved across the wrap.
- Flush with in_valid_i=1 (pc_i=0x200) at count=3 → next cycle count_o=0, out_valid_o=0, inst_o=NOP. 0x200 is never output. The next push 0x300 appears after 1 cycle.
- Flush and hold both asserted at count=2 → flush wins; count_o=0. pc_o retains the last popped PC.
- Bypass (macro defined), empty, push 0x400 with hold_i=0 → out_valid_o=1 and pc_o=0x400 in the same cycle; count_o stays 0. Without the macro, the same stimulus yields 0x400 one cycle later.
